// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller beside decode: load-use stalls, EX redirect flushes,
// the multi-cycle sprite-unit handshake with timeout, and HALT.
module pipe_hazard_ctrl #(
  parameter int SPR_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_regS_addr,
  input  logic [4:0] id_regT_addr,
  input  logic       id_reS,
  input  logic       id_reT,
  input  logic       id_sprite_req,
  input  logic       id_hlt,
  input  logic [4:0] ex_dst_reg,
  input  logic       ex_use_dst_reg,
  input  logic       ex_load,
  input  logic       ex_branch_taken,
  input  logic       spr_ack,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       bubble_id_ex,
  output logic       flush_if_id,
  output logic       spr_start,
  output logic       halted,
  output logic       spr_timeout_err
);

  typedef enum logic [1:0] {RUN, SPR_WAIT, HALTED} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPR_TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_set;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic             start;
  logic             load_use;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_load & ex_use_dst_reg & (ex_dst_reg != 5'd0) &
                    ((id_reS & (id_regS_addr == ex_dst_reg)) |
                     (id_reT & (id_regT_addr == ex_dst_reg)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      cnt             <= '0;
      spr_timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (err_set) spr_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    stall     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    start     = 1'b0;
    unique case (state)
      RUN: begin
        if (ex_branch_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (load_use) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end else if (id_hlt) begin
          stall     = 1'b1;
          bubble    = 1'b1;
          state_nxt = HALTED;
        end else if (id_sprite_req) begin
          start     = 1'b1;
          stall     = 1'b1;
          bubble    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SPR_WAIT;
        end
      end
      SPR_WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        // Ack or timeout releases the stall in the same cycle so the sprite instr advances.
        if (spr_ack) begin
          state_nxt = RUN;
        end else if (cnt == CNT_LAST) begin
          err_set   = 1'b1;
          state_nxt = RUN;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      HALTED: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    // Combinational outputs still see live inputs while reset holds RUN; force them quiet.
    if (rst) begin
      stall  = 1'b0;
      bubble = 1'b0;
      flush  = 1'b0;
      start  = 1'b0;
    end
  end

  assign stall_pc     = stall;
  assign stall_if_id  = stall;
  assign bubble_id_ex = bubble;
  assign flush_if_id  = flush;
  assign spr_start    = start;
  assign halted       = (state == HALTED);

endmodule
